// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one programmable serial
// pattern detector among N_CH requesters. At most one bit is accepted per
// cycle. Each channel keeps its own bit history and fill count, so channel
// streams are matched independently.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   cfg_load     strobe: latch cfg_* and clear histories (priority over transfers)
//   cfg_pattern  pattern, bit 0 = most recent bit
//   cfg_len      pattern length, legal 1..MAXLEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   req_valid    per-channel bit available
//   req_bit      per-channel serial data bit
//   req_ready    one-hot grant (bit consumed on valid & ready)
//   match        registered one-cycle match pulse
//   match_ch     channel of the last match
//   match_count  saturating match total since reset / legal cfg_load
//   cfg_err      sticky: last cfg_load carried an illegal cfg_len
//
// state  | meaning
// -------+---------------------------------------------
// ST_CFG | no legal configuration, no grants issued
// ST_RUN | configured, arbitrating and detecting
module seq_det_sched #(
  parameter int N_CH   = 4,
  parameter int CHW    = 2,
  parameter int MAXLEN = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH-1:0]   req_bit,
  output logic [N_CH-1:0]   req_ready,
  output logic              match,
  output logic [CHW-1:0]    match_ch,
  output logic [CNTW-1:0]   match_count,
  output logic              cfg_err
);

  typedef enum logic {ST_CFG, ST_RUN} state_t;

  state_t              state, state_nx;
  logic [MAXLEN-1:0]   pat_q;
  logic [3:0]          len_q;
  logic                ovl_q;
  logic [CHW-1:0]      ptr;
  logic [MAXLEN-1:0]   hist [N_CH];
  logic [3:0]          fcnt [N_CH];

  logic                cfg_legal;
  logic                xfer;
  logic [CHW-1:0]      gnt_idx;
  logic [MAXLEN-1:0]   upd_hist;
  logic [3:0]          upd_fcnt;
  logic [MAXLEN-1:0]   mask;
  logic                hit;

  assign cfg_legal = (cfg_len != 4'd0) && (int'(cfg_len) <= MAXLEN);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_CFG;
    else      state <= state_nx;
  end

  // Next state plus round-robin grant. The search starts at ptr and wraps,
  // so the channel after the last winner has top priority.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    xfer      = 1'b0;
    gnt_idx   = '0;
    if (cfg_load) state_nx = cfg_legal ? ST_RUN : ST_CFG;
    if (state == ST_RUN && !cfg_load) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!xfer && req_valid[(int'(ptr) + k) % N_CH]) begin
          xfer    = 1'b1;
          gnt_idx = CHW'((int'(ptr) + k) % N_CH);
        end
      end
      if (xfer) req_ready[gnt_idx] = 1'b1;
    end
  end

  // Detection on the granted channel's post-update history.
  always_comb begin
    upd_hist = {hist[gnt_idx][MAXLEN-2:0], req_bit[gnt_idx]};
    upd_fcnt = (fcnt[gnt_idx] >= len_q) ? len_q : fcnt[gnt_idx] + 4'd1;
    mask     = '0;
    for (int i = 0; i < MAXLEN; i++) mask[i] = (i < int'(len_q));
    hit = xfer && (upd_fcnt == len_q) && (((upd_hist ^ pat_q) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      ptr         <= '0;
      match       <= 1'b0;
      match_ch    <= '0;
      match_count <= '0;
      cfg_err     <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        hist[c] <= '0;
        fcnt[c] <= '0;
      end
    end else begin
      match <= 1'b0;
      if (cfg_load) begin
        if (cfg_legal) begin
          pat_q       <= cfg_pattern;
          len_q       <= cfg_len;
          ovl_q       <= cfg_overlap;
          match_count <= '0;
          cfg_err     <= 1'b0;
          for (int c = 0; c < N_CH; c++) begin
            hist[c] <= '0;
            fcnt[c] <= '0;
          end
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (xfer) begin
        hist[gnt_idx] <= upd_hist;
        // Non-overlap restarts the fill so a full fresh pattern is needed.
        fcnt[gnt_idx] <= (hit && !ovl_q) ? 4'd0 : upd_fcnt;
        ptr           <= (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        match         <= hit;
        if (hit) begin
          match_ch <= gnt_idx;
          if (match_count != '1) match_count <= match_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
module tb_seq_det_sched;

  logic        clk;
  logic        rst;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [3:0]  req_valid;
  logic [3:0]  req_bit;
  logic [3:0]  req_ready;
  logic        match;
  logic [1:0]  match_ch;
  logic [15:0] match_count;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;

  seq_det_sched dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .req_valid(req_valid),
    .req_bit(req_bit), .req_ready(req_ready), .match(match),
    .match_ch(match_ch), .match_count(match_count), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
  endtask

  // Offer one bit on a single channel; returns grant seen before the edge
  // and match outputs seen after it.
  task automatic xfer(input int ch, input logic b, output logic [3:0] rdy,
                      output logic m, output logic [1:0] mc);
    req_valid     = 4'b0001 << ch;
    req_bit       = '0;
    req_bit[ch]   = b;
    #1;
    rdy = req_ready;
    tick();
    m  = match;
    mc = match_ch;
    req_valid = '0;
    req_bit   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++;
    if ({match, match_ch, match_count, cfg_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got match=%b ch=%0d cnt=%0d err=%b exp all 0", match, match_ch, match_count, cfg_err);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL cfg_state_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
  endtask

  task automatic run_stream(input string name, input logic ovl, input logic [6:0] em);
    logic [6:0] sb;
    logic [3:0] rdy;
    logic m;
    logic [1:0] mc;
    sb = 7'b1011011;
    do_cfg(8'b0000_1101, 4'd4, ovl);
    for (int i = 0; i < 7; i++) begin
      xfer(0, sb[i], rdy, m, mc);
      checks++;
      if (rdy !== 4'b0001) begin errors++; $display("FAIL %s_ready bit%0d got=%b exp=0001", name, i, rdy); end
      checks++;
      if (m !== em[i]) begin errors++; $display("FAIL %s_match bit%0d got=%b exp=%b", name, i, m, em[i]); end
      if (em[i]) begin
        checks++;
        if (mc !== 2'd0) begin errors++; $display("FAIL %s_ch bit%0d got=%0d exp=0", name, i, mc); end
      end
    end
  endtask

  task automatic test_overlap();
    run_stream("ovl", 1'b1, 7'b1001000);
    checks++;
    if (match_count !== 16'd2) begin errors++; $display("FAIL ovl_count got=%0d exp=2", match_count); end
  endtask

  task automatic test_nonoverlap();
    run_stream("novl", 1'b0, 7'b0001000);
    checks++;
    if (match_count !== 16'd1) begin errors++; $display("FAIL novl_count got=%0d exp=1", match_count); end
  endtask

  task automatic test_cfg_clear();
    logic [3:0] rdy;
    logic m;
    logic [1:0] mc;
    logic [3:0] sb;
    logic [3:0] em;
    do_cfg(8'b0000_1101, 4'd4, 1'b1);
    xfer(0, 1'b1, rdy, m, mc);
    xfer(0, 1'b1, rdy, m, mc);
    xfer(0, 1'b0, rdy, m, mc);
    do_cfg(8'b0000_1101, 4'd4, 1'b1);
    xfer(0, 1'b1, rdy, m, mc);
    checks++;
    if (m !== 1'b0) begin errors++; $display("FAIL clr_stale_match got=%b exp=0", m); end
    sb = 4'b1011;
    em = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      xfer(0, sb[i], rdy, m, mc);
      checks++;
      if (m !== em[i]) begin errors++; $display("FAIL clr_match bit%0d got=%b exp=%b", i, m, em[i]); end
    end
  endtask

  task automatic test_len1();
    logic [3:0] rdy;
    logic m;
    logic [1:0] mc;
    logic [2:0] sb;
    sb = 3'b101;
    do_cfg(8'b1111_1101, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      xfer(0, sb[i], rdy, m, mc);
      checks++;
      if (m !== sb[i]) begin errors++; $display("FAIL len1_match bit%0d got=%b exp=%b", i, m, sb[i]); end
    end
    checks++;
    if (match_count !== 16'd2) begin errors++; $display("FAIL len1_count got=%0d exp=2", match_count); end
  endtask

  task automatic test_rst_mid();
    logic [3:0] rdy;
    logic m;
    logic [1:0] mc;
    logic [3:0] sb;
    sb = 4'b1011;
    do_cfg(8'b0000_1101, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) xfer(2, sb[i], rdy, m, mc);
    checks++;
    if ({m, mc, match_count} !== {1'b1, 2'd2, 16'd1}) begin
      errors++;
      $display("FAIL pre_rst_match got m=%b ch=%0d cnt=%0d exp m=1 ch=2 cnt=1", m, mc, match_count);
    end
    xfer(2, 1'b1, rdy, m, mc);
    xfer(2, 1'b0, rdy, m, mc);
    // Next bit would complete 1101 again; reset lands on the same edge.
    req_valid = 4'b0100;
    req_bit   = 4'b0100;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({match, match_ch, match_count, cfg_err} !== 20'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got match=%b ch=%0d cnt=%0d err=%b exp all 0", match, match_ch, match_count, cfg_err);
    end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0000", req_ready); end
    tick();
    checks++;
    if (req_ready !== 4'b0000 || match !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold got ready=%b match=%b exp 0000/0", req_ready, match);
    end
    req_valid = '0;
    req_bit   = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] sb;
    logic [3:0] exp_rdy;
    logic       b;
    logic       exp_m;
    do_cfg(8'b0000_1101, 4'd4, 1'b1);
    sb = 4'b1011;
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      b = sb[k / 4];
      req_bit = {1'b0, b, 1'b0, b};
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready cyc%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      tick();
      exp_m = (k == 12) || (k == 14);
      checks++;
      if (match !== exp_m) begin errors++; $display("FAIL rr_match cyc%0d got=%b exp=%b", k, match, exp_m); end
      if (exp_m) begin
        checks++;
        if (match_ch !== 2'(k % 4)) begin errors++; $display("FAIL rr_ch cyc%0d got=%0d exp=%0d", k, match_ch, k % 4); end
      end
    end
    req_valid = '0;
    req_bit   = '0;
    checks++;
    if (match_count !== 16'd2) begin errors++; $display("FAIL rr_count got=%0d exp=2", match_count); end
  endtask

  task automatic test_cfg_err();
    do_cfg(8'b0000_0101, 4'd0, 1'b1);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_len0 got=%b exp=1", cfg_err); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL err_ready got=%b exp=0000", req_ready); end
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL err_ready_hold got=%b exp=0000", req_ready); end
    req_valid = '0;
    do_cfg(8'b0000_0101, 4'd9, 1'b1);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_len9 got=%b exp=1", cfg_err); end
    do_cfg(8'b0000_0101, 4'd3, 1'b1);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", cfg_err); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL err_resume got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    cfg_load = 1'b0;
    cfg_pattern = '0;
    cfg_len = '0;
    cfg_overlap = 1'b0;
    req_valid = '0;
    req_bit = '0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_cfg_clear();
    test_len1();
    test_rst_mid();
    test_back_to_back();
    test_cfg_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
